ts_header_monitor: RTL and testbench

TS_HEADER_MONITOR -- requirements
Module: ts_header_monitor

---
 rtl/ts_pkg.sv | 58 +++++
 rtl/ts_cc_table.sv | 75 +++++++
 rtl/ts_header_monitor.sv | 193 +++++++++++++++++++
 tb/tb_ts_header_monitor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ts_pkg
// Description : Shared MPEG-TS constants, parser state encoding and the
//               continuity-counter evaluation rule.
// Revision    : 1.0 - initial release
// ============================================================================
package ts_pkg;

    localparam int          TS_PKT_LEN = 188;
    localparam logic [7:0]  SYNC_BYTE  = 8'h47;
    localparam logic [12:0] NULL_PID   = 13'h1FFF;

    localparam logic [1:0]  AFC_RESERVED      = 2'b00;
    localparam logic [1:0]  AFC_PAYLOAD_ONLY  = 2'b01;
    localparam logic [1:0]  AFC_ADAPT_ONLY    = 2'b10;
    localparam logic [1:0]  AFC_ADAPT_PAYLOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } parse_state_t;

    typedef struct packed {
        logic err;
        logic dup;
    } cc_result_t;

    function automatic logic afc_has_payload(input logic [1:0] afc);
        return (afc == AFC_PAYLOAD_ONLY) || (afc == AFC_ADAPT_PAYLOAD);
    endfunction

    // Payload packets may advance by one or repeat once; others must not move.
    function automatic cc_result_t cc_eval(input logic [1:0] afc,
                                           input logic [3:0] rx_cc,
                                           input logic [3:0] stored_cc,
                                           input logic       dup);
        cc_result_t res;
        res.err = 1'b0;
        res.dup = dup;
        if (afc_has_payload(afc)) begin
            if (rx_cc == 4'(stored_cc + 4'd1)) begin
                res.dup = 1'b0;
            end else if ((rx_cc == stored_cc) && !dup) begin
                res.dup = 1'b1;
            end else begin
                res.err = 1'b1;
                res.dup = 1'b0;
            end
        end else begin
            res.err = (rx_cc != stored_cc);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_cc_table.sv
`default_nettype none
// ============================================================================
// Module      : ts_cc_table
// Description : Fully parallel PID/continuity-counter table with lowest-free
//               slot allocation and per-header CC checking.
// Revision    : 1.0 - initial release
// ============================================================================
module ts_cc_table
    import ts_pkg::*;
#(
    parameter int NUM_PID_SLOTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        check_en,
    input  logic [12:0] pid,
    input  logic        tei,
    input  logic [1:0]  afc,
    input  logic [3:0]  cc,
    output logic        cc_error,
    output logic        table_full
);

    logic [NUM_PID_SLOTS-1:0] w_slot_valid;
    logic [NUM_PID_SLOTS-1:0] w_slot_hit;
    logic [NUM_PID_SLOTS-1:0] w_slot_err;
    logic [NUM_PID_SLOTS-1:0] w_free;
    logic [NUM_PID_SLOTS-1:0] w_first_free;
    logic                     w_eligible;
    logic                     w_any_hit;

    assign w_eligible   = check_en && !tei && (pid != NULL_PID);
    assign w_free       = ~w_slot_valid;
    // Isolate the lowest set bit of the free mask.
    assign w_first_free = w_free & (~w_free + NUM_PID_SLOTS'(1));
    assign w_any_hit    = |w_slot_hit;
    assign cc_error     = w_eligible && |(w_slot_hit & w_slot_err);
    assign table_full   = &w_slot_valid;

    generate
        for (genvar g = 0; g < NUM_PID_SLOTS; g++) begin : g_slot
            logic        r_valid;
            logic        r_dup;
            logic [12:0] r_pid;
            logic [3:0]  r_cc;
            cc_result_t  w_res;

            assign w_res           = cc_eval(afc, cc, r_cc, r_dup);
            assign w_slot_valid[g] = r_valid;
            assign w_slot_hit[g]   = r_valid && (r_pid == pid);
            assign w_slot_err[g]   = w_res.err;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_dup   <= 1'b0;
                    r_pid   <= '0;
                    r_cc    <= '0;
                end else if (w_eligible) begin
                    if (w_slot_hit[g]) begin
                        r_cc  <= cc;
                        r_dup <= w_res.dup;
                    end else if (!w_any_hit && w_first_free[g]) begin
                        r_valid <= 1'b1;
                        r_pid   <= pid;
                        r_cc    <= cc;
                        r_dup   <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ts_header_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ts_header_monitor
// Description : Transport-stream header parser with continuity checking,
//               error pulses and saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ts_header_monitor
    import ts_pkg::*;
#(
    parameter int NUM_PID_SLOTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    input  logic        valid,
    input  logic [7:0]  byte_in,
    output logic        hdr_valid,
    output logic [12:0] pid,
    output logic        tei,
    output logic        pusi,
    output logic [1:0]  afc,
    output logic [3:0]  cc,
    output logic        cc_error,
    output logic        tei_error,
    output logic        table_full,
    output logic [31:0] pkt_count,
    output logic [15:0] cc_err_count,
    output logic [15:0] tei_err_count
);

    localparam logic [7:0] C_LAST_IDX = 8'(TS_PKT_LEN - 1);

    parse_state_t r_state;
    parse_state_t w_state_nxt;
    logic [7:0]   r_idx;
    logic [7:0]   w_idx_nxt;
    logic         w_cap_b1;
    logic         w_cap_b2;
    logic         w_cap_b3;

    logic         r_b1_tei;
    logic         r_b1_pusi;
    logic [4:0]   r_pid_hi;
    logic [7:0]   r_pid_lo;

    logic         r_hdr_valid;
    logic [12:0]  r_pid;
    logic         r_tei;
    logic         r_pusi;
    logic [1:0]   r_afc;
    logic [3:0]   r_cc;

    logic [31:0]  r_pkt_count;
    logic [15:0]  r_cc_err_count;
    logic [15:0]  r_tei_err_count;

    logic         w_cc_error;
    logic         w_tei_error;
    logic         w_table_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A qualified sync always wins, so a mid-packet resync silently drops the old packet.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cap_b1    = 1'b0;
        w_cap_b2    = 1'b0;
        w_cap_b3    = 1'b0;
        if (valid && sync) begin
            w_state_nxt = ST_HDR;
            w_idx_nxt   = '0;
        end else if (valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_HDR: begin
                    w_idx_nxt = r_idx + 8'd1;
                    w_cap_b1  = (w_idx_nxt == 8'd1);
                    w_cap_b2  = (w_idx_nxt == 8'd2);
                    w_cap_b3  = (w_idx_nxt == 8'd3);
                    if (w_cap_b3) begin
                        w_state_nxt = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (r_idx == C_LAST_IDX - 8'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Header bytes land in shadow registers so the published fields stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b1_tei    <= 1'b0;
            r_b1_pusi   <= 1'b0;
            r_pid_hi    <= '0;
            r_pid_lo    <= '0;
            r_hdr_valid <= 1'b0;
            r_pid       <= '0;
            r_tei       <= 1'b0;
            r_pusi      <= 1'b0;
            r_afc       <= '0;
            r_cc        <= '0;
        end else begin
            r_hdr_valid <= w_cap_b3;
            if (w_cap_b1) begin
                r_b1_tei  <= byte_in[7];
                r_b1_pusi <= byte_in[6];
                r_pid_hi  <= byte_in[4:0];
            end
            if (w_cap_b2) begin
                r_pid_lo <= byte_in;
            end
            if (w_cap_b3) begin
                r_tei  <= r_b1_tei;
                r_pusi <= r_b1_pusi;
                r_pid  <= {r_pid_hi, r_pid_lo};
                r_afc  <= byte_in[5:4];
                r_cc   <= byte_in[3:0];
            end
        end
    end

    ts_cc_table #(
        .NUM_PID_SLOTS (NUM_PID_SLOTS)
    ) u_cc_table (
        .clk        (clk),
        .rst        (rst),
        .check_en   (r_hdr_valid),
        .pid        (r_pid),
        .tei        (r_tei),
        .afc        (r_afc),
        .cc         (r_cc),
        .cc_error   (w_cc_error),
        .table_full (w_table_full)
    );

    assign w_tei_error = r_hdr_valid && r_tei;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count     <= '0;
            r_cc_err_count  <= '0;
            r_tei_err_count <= '0;
        end else begin
            if (r_hdr_valid && (r_pkt_count != '1)) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_cc_error && (r_cc_err_count != '1)) begin
                r_cc_err_count <= r_cc_err_count + 16'd1;
            end
            if (w_tei_error && (r_tei_err_count != '1)) begin
                r_tei_err_count <= r_tei_err_count + 16'd1;
            end
        end
    end

    assign hdr_valid     = r_hdr_valid;
    assign pid           = r_pid;
    assign tei           = r_tei;
    assign pusi          = r_pusi;
    assign afc           = r_afc;
    assign cc            = r_cc;
    assign cc_error      = w_cc_error;
    assign tei_error     = w_tei_error;
    assign table_full    = w_table_full;
    assign pkt_count     = r_pkt_count;
    assign cc_err_count  = r_cc_err_count;
    assign tei_err_count = r_tei_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ts_header_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_header_monitor
// Description : Directed and randomized self-checking bench for
//               ts_header_monitor against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_header_monitor;
    import ts_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync;
    logic        valid;
    logic [7:0]  byte_in;
    logic        hdr_valid;
    logic [12:0] pid;
    logic        tei;
    logic        pusi;
    logic [1:0]  afc;
    logic [3:0]  cc;
    logic        cc_error;
    logic        tei_error;
    logic        table_full;
    logic [31:0] pkt_count;
    logic [15:0] cc_err_count;
    logic [15:0] tei_err_count;

    always #5 clk = ~clk;

    ts_header_monitor #(.NUM_PID_SLOTS(N)) dut (
        .clk(clk), .rst(rst), .sync(sync), .valid(valid), .byte_in(byte_in),
        .hdr_valid(hdr_valid), .pid(pid), .tei(tei), .pusi(pusi), .afc(afc),
        .cc(cc), .cc_error(cc_error), .tei_error(tei_error),
        .table_full(table_full), .pkt_count(pkt_count),
        .cc_err_count(cc_err_count), .tei_err_count(tei_err_count)
    );

    typedef struct {
        logic [12:0] pid;
        logic        tei;
        logic        pusi;
        logic [1:0]  afc;
        logic [3:0]  cc;
        logic        cc_error;
        logic        tei_error;
    } hdr_t;

    hdr_t q_hdr[$];
    int   n_stray = 0;
    logic prev_hdr = 1'b0;

    always @(negedge clk) begin
        if (hdr_valid) q_hdr.push_back('{pid, tei, pusi, afc, cc, cc_error, tei_error});
        if ((cc_error || tei_error) && !hdr_valid) n_stray++;
        if (hdr_valid && prev_hdr) n_stray++;
        prev_hdr = hdr_valid;
    end

    // Reference model: list of tracked PIDs with last cc and duplicate flag.
    logic [12:0] m_pid[$];
    logic [3:0]  m_cc[$];
    bit          m_dup[$];
    int          e_pkt, e_ccc, e_teic;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pid.delete(); m_cc.delete(); m_dup.delete();
        e_pkt = 0; e_ccc = 0; e_teic = 0;
        q_hdr.delete();
    endtask

    task automatic model_pkt(input logic [12:0] p, input logic t, input logic [1:0] a,
                             input logic [3:0] c, output logic e_cc);
        int k = -1;
        e_cc = 1'b0;
        e_pkt++;
        if (t) e_teic++;
        if (!t && p != 13'h1FFF) begin
            foreach (m_pid[i]) if (m_pid[i] == p) k = i;
            if (k < 0) begin
                if (m_pid.size() < N) begin
                    m_pid.push_back(p); m_cc.push_back(c); m_dup.push_back(1'b0);
                end
            end else begin
                if (a == 2'b01 || a == 2'b11) begin
                    if (int'(c) == (int'(m_cc[k]) + 1) % 16) m_dup[k] = 1'b0;
                    else if (c == m_cc[k] && !m_dup[k]) m_dup[k] = 1'b1;
                    else begin e_cc = 1'b1; m_dup[k] = 1'b0; end
                end else begin
                    e_cc = (c != m_cc[k]);
                end
                m_cc[k] = c;
            end
        end
        if (e_cc) e_ccc++;
    endtask

    task automatic drive_byte(input logic s, input logic [7:0] b, input int holes_max);
        int h;
        h = (holes_max > 0) ? int'($urandom_range(0, holes_max)) : 0;
        repeat (h) begin
            @(negedge clk);
            valid = 1'b0; sync = 1'($urandom); byte_in = 8'($urandom);
        end
        @(negedge clk);
        valid = 1'b1; sync = s; byte_in = b;
    endtask

    task automatic send_pkt(input logic [12:0] p, input logic t, input logic pu,
                            input logic [1:0] a, input logic [3:0] c,
                            input int first, input int last, input int holes);
        logic [7:0] b;
        for (int i = first; i <= last; i++) begin
            case (i)
                0:       b = SYNC_BYTE;
                1:       b = {t, pu, 1'($urandom), p[12:8]};
                2:       b = p[7:0];
                3:       b = {2'($urandom), a, c};
                default: b = 8'($urandom);
            endcase
            drive_byte(i == 0, b, holes);
        end
        @(negedge clk);
        valid = 1'b0; sync = 1'b0;
    endtask

    task automatic check_pkt(input logic [12:0] p, input logic t, input logic pu,
                             input logic [1:0] a, input logic [3:0] c, input string tag);
        logic e_cc;
        hdr_t h;
        model_pkt(p, t, a, c, e_cc);
        chk({tag, "_pulses"}, 32'(q_hdr.size()), 32'd1);
        if (q_hdr.size() >= 1) begin
            h = q_hdr.pop_front();
            chk({tag, "_pid"},       32'(h.pid),       32'(p));
            chk({tag, "_tei"},       32'(h.tei),       32'(t));
            chk({tag, "_pusi"},      32'(h.pusi),      32'(pu));
            chk({tag, "_afc"},       32'(h.afc),       32'(a));
            chk({tag, "_cc"},        32'(h.cc),        32'(c));
            chk({tag, "_cc_error"},  32'(h.cc_error),  32'(e_cc));
            chk({tag, "_tei_error"}, 32'(h.tei_error), 32'(t));
        end
        q_hdr.delete();
        chk({tag, "_pkt_count"},     pkt_count,            32'(e_pkt));
        chk({tag, "_cc_err_count"},  32'(cc_err_count),    32'(e_ccc));
        chk({tag, "_tei_err_count"}, 32'(tei_err_count),   32'(e_teic));
        chk({tag, "_table_full"},    32'(table_full),      32'(m_pid.size() == N));
    endtask

    task automatic do_pkt(input logic [12:0] p, input logic t, input logic pu,
                          input logic [1:0] a, input logic [3:0] c,
                          input int holes, input string tag);
        send_pkt(p, t, pu, a, c, 0, TS_PKT_LEN - 1, holes);
        check_pkt(p, t, pu, a, c, tag);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    logic [12:0] pool[10];
    logic [3:0]  last_cc[10];
    int          sel, roll;
    logic [3:0]  rc;
    logic [1:0]  ra;
    logic        rt;

    initial begin
        rst = 1'b1; valid = 1'b0; sync = 1'b0; byte_in = 8'h00;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_hdr_valid",     32'(hdr_valid),     32'd0);
        chk("rst_pid",           32'(pid),           32'd0);
        chk("rst_tei",           32'(tei),           32'd0);
        chk("rst_pusi",          32'(pusi),          32'd0);
        chk("rst_afc",           32'(afc),           32'd0);
        chk("rst_cc",            32'(cc),            32'd0);
        chk("rst_cc_error",      32'(cc_error),      32'd0);
        chk("rst_tei_error",     32'(tei_error),     32'd0);
        chk("rst_table_full",    32'(table_full),    32'd0);
        chk("rst_pkt_count",     pkt_count,          32'd0);
        chk("rst_cc_err_count",  32'(cc_err_count),  32'd0);
        chk("rst_tei_err_count", 32'(tei_err_count), 32'd0);
        rst = 1'b0;

        // Clean continuity run on PID 0x0100.
        for (int k = 0; k < 17; k++)
            do_pkt(13'h0100, 1'b0, k == 0, 2'b01, 4'(k % 16), k % 2, $sformatf("clean%0d", k));
        chk("clean_pkt_count", pkt_count, 32'd17);
        chk("clean_cc_errs",   32'(cc_err_count), 32'd0);

        // Duplicate allowed once, second duplicate flagged.
        do_reset();
        do_pkt(13'h0100, 1'b0, 1'b1, 2'b01, 4'd3, 1, "dup0");
        do_pkt(13'h0100, 1'b0, 1'b0, 2'b01, 4'd4, 1, "dup1");
        do_pkt(13'h0100, 1'b0, 1'b0, 2'b01, 4'd4, 1, "dup2");
        do_pkt(13'h0100, 1'b0, 1'b0, 2'b01, 4'd4, 1, "dup3");
        chk("dup_cc_err_count", 32'(cc_err_count), 32'd1);

        // TEI packet is reported but never allocates a slot.
        do_reset();
        do_pkt(13'h0033, 1'b1, 1'b0, 2'b01, 4'd5, 0, "tei0");
        chk("tei_err_count_1", 32'(tei_err_count), 32'd1);
        do_pkt(13'h0033, 1'b0, 1'b0, 2'b01, 4'd9, 0, "tei1");
        do_pkt(13'h0033, 1'b0, 1'b0, 2'b10, 4'd3, 0, "tei2");

        // Table exhaustion: the ninth PID is never checked.
        do_reset();
        for (int k = 0; k < 9; k++)
            do_pkt(13'(13'h0200 + k * 7), 1'b0, 1'b1, 2'b01, 4'($urandom), 0, $sformatf("fill%0d", k));
        chk("fill_table_full", 32'(table_full), 32'd1);
        do_pkt(13'(13'h0200 + 8 * 7), 1'b0, 1'b0, 2'b01, 4'd0, 0, "untracked0");
        do_pkt(13'(13'h0200 + 8 * 7), 1'b0, 1'b0, 2'b00, 4'd7, 0, "untracked1");
        do_pkt(13'h0200, 1'b0, 1'b0, 2'b01, 4'($urandom), 0, "tracked_still");

        // Resync aborts, bytes without sync in IDLE are ignored.
        do_reset();
        send_pkt(13'h0ABC, 1'b0, 1'b1, 2'b11, 4'd2, 0, 100, 3);
        check_pkt(13'h0ABC, 1'b0, 1'b1, 2'b11, 4'd2, "abort_first");
        do_pkt(13'h0123, 1'b0, 1'b1, 2'b01, 4'd6, 3, "resync");
        send_pkt(13'h0777, 1'b0, 1'b1, 2'b01, 4'd1, 0, 2, 3);
        do_pkt(13'h0124, 1'b0, 1'b0, 2'b11, 4'd8, 3, "resync_early");
        send_pkt(13'h0555, 1'b0, 1'b0, 2'b01, 4'd1, 4, 40, 1);
        chk("idle_ignored_pulses", 32'(q_hdr.size()), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        pool[0] = NULL_PID;
        for (int i = 1; i < 10; i++) pool[i] = 13'($urandom_range(0, 8190));
        for (int i = 0; i < 10; i++) last_cc[i] = 4'($urandom);
        for (int n = 0; n < 30; n++) begin
            sel  = $urandom_range(0, 9);
            roll = $urandom_range(0, 9);
            ra   = 2'($urandom);
            rt   = ($urandom_range(0, 9) == 0);
            if (roll < 7)      rc = last_cc[sel] + 4'd1;
            else if (roll < 8) rc = last_cc[sel];
            else               rc = 4'($urandom);
            last_cc[sel] = rc;
            do_pkt(pool[sel], rt, 1'($urandom), ra, rc, 2, $sformatf("rnd%0d", n));
        end

        // Asynchronous reset in the middle of a header.
        q_hdr.delete();
        send_pkt(13'h0042, 1'b0, 1'b1, 2'b01, 4'd3, 0, 2, 0);
        @(negedge clk); #2 rst = 1'b1;
        #1 chk("arst_pkt_count_async", pkt_count, 32'd0);
        @(negedge clk); rst = 1'b0;
        model_clear();
        send_pkt(13'h0042, 1'b0, 1'b1, 2'b01, 4'd3, 3, TS_PKT_LEN - 1, 0);
        chk("arst_no_pulse",      32'(q_hdr.size()),     32'd0);
        chk("arst_pkt_count",     pkt_count,             32'd0);
        chk("arst_cc_err_count",  32'(cc_err_count),     32'd0);
        chk("arst_tei_err_count", 32'(tei_err_count),    32'd0);
        chk("arst_table_full",    32'(table_full),       32'd0);
        do_pkt(13'h0042, 1'b0, 1'b1, 2'b01, 4'd3, 1, "after_arst");

        chk("stray_pulses", 32'(n_stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
